// File: rtl/led_seq_pkg.sv
// led_seq_pkg: register indices, mode/state encodings and bounce directions for the LED sequencer
package led_seq_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_PERIOD  = 3'd1;
    localparam logic [2:0] REG_PATTERN = 3'd2;
    localparam logic [2:0] REG_STEPS   = 3'd3;

    typedef enum logic [2:0] {
        MODE_STATIC = 3'd0,
        MODE_WALK   = 3'd1,
        MODE_BOUNCE = 3'd2,
        MODE_COUNT  = 3'd3,
        MODE_BLINK  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_pattern_sequencer_prescaler.sv
// led_prescaler: free-running step prescaler, ticks once every period+1 enabled cycles
module led_prescaler #(
    parameter int PRESC_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [PRESC_WIDTH-1:0] period,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] cnt_q;

    // Compare is against the live period so a shortened period ticks on the next cycle
    assign tick = !clr && (cnt_q >= period);

    // Count while enabled, restart from zero on each tick, park at zero while cleared
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt_q <= '0;
        else if (clr || tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + PRESC_WIDTH'(1);

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: register-programmed LED pattern generator with a prescaled step FSM
import led_seq_pkg::*;

module led_pattern_sequencer #(
    parameter int LED_WIDTH      = 8,
    parameter int PRESC_WIDTH    = 24,
    parameter int STEP_WIDTH     = 16,
    parameter int DEFAULT_PERIOD = 9_999_999
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESET,
    input  logic                 slv_reg_wren,
    input  logic [2:0]           axi_awaddr,
    input  logic [31:0]          S_AXI_WDATA,
    output logic [LED_WIDTH-1:0] LED,
    output logic                 seq_busy,
    output logic                 seq_done
);

    logic [3:0]             ctrl_q;
    logic [PRESC_WIDTH-1:0] period_q;
    logic [LED_WIDTH-1:0]   pattern_q;
    logic [STEP_WIDTH-1:0]  steps_q;

    state_e                 state_q;
    logic [LED_WIDTH-1:0]   led_q;
    logic [STEP_WIDTH-1:0]  step_cnt_q;
    logic                   dir_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   wr_ctrl;
    logic [2:0]             mode;
    logic [2:0]             wr_mode;
    logic [LED_WIDTH-1:0]   seed;
    logic [LED_WIDTH-1:0]   shifted;
    logic [LED_WIDTH-1:0]   led_d;
    logic                   dir_d;
    logic [STEP_WIDTH:0]    step_inc;
    logic                   last_step;
    logic                   tick;
    logic                   unused_bits;

    assign wr_ctrl     = slv_reg_wren && (axi_awaddr == REG_CTRL);
    assign mode        = ctrl_q[3:1];
    assign wr_mode     = S_AXI_WDATA[3:1];
    assign unused_bits = ^{S_AXI_WDATA, ctrl_q[0]};

    // An empty pattern would leave walk/bounce dark forever, so those modes start from bit 0
    assign seed = (pattern_q == '0 && (wr_mode == MODE_WALK || wr_mode == MODE_BOUNCE))
                  ? LED_WIDTH'(1) : pattern_q;

    // One extra bit keeps the reach-STEPS compare correct when step_cnt wraps in free-run
    assign step_inc  = {1'b0, step_cnt_q} + (STEP_WIDTH+1)'(1);
    assign last_step = (steps_q != '0) && (step_inc >= {1'b0, steps_q});

    assign LED      = led_q;
    assign seq_busy = busy_q;
    assign seq_done = done_q;

    led_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_presc (
        .clk   (S_AXI_ACLK),
        .rst   (S_AXI_ARESET),
        .clr   ((state_q != ST_RUN) || wr_ctrl),
        .period(period_q),
        .tick  (tick)
    );

    // Next LED value per mode; bounce turns around based on where the shifted bit lands
    always_comb begin
        shifted = (dir_q == DIR_RIGHT) ? (led_q >> 1) : (led_q << 1);
        dir_d   = (mode != MODE_BOUNCE)     ? dir_q :
                  shifted[LED_WIDTH-1]      ? DIR_RIGHT :
                  shifted[0]                ? DIR_LEFT : dir_q;
        led_d   = (mode == MODE_WALK)   ? {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]} :
                  (mode == MODE_BOUNCE) ? shifted :
                  (mode == MODE_COUNT)  ? led_q + LED_WIDTH'(1) :
                  (mode == MODE_BLINK)  ? ~led_q : pattern_q;
    end

    // Software-visible registers; indices 4-7 decode to nothing
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
        if (S_AXI_ARESET) begin
            ctrl_q    <= '0;
            period_q  <= PRESC_WIDTH'(DEFAULT_PERIOD);
            pattern_q <= LED_WIDTH'(1);
            steps_q   <= '0;
        end else if (slv_reg_wren) begin
            if (axi_awaddr == REG_CTRL)    ctrl_q    <= S_AXI_WDATA[3:0];
            if (axi_awaddr == REG_PERIOD)  period_q  <= S_AXI_WDATA[PRESC_WIDTH-1:0];
            if (axi_awaddr == REG_PATTERN) pattern_q <= S_AXI_WDATA[LED_WIDTH-1:0];
            if (axi_awaddr == REG_STEPS)   steps_q   <= S_AXI_WDATA[STEP_WIDTH-1:0];
        end

    // Sequencer FSM: a CTRL write overrides any same-cycle tick, otherwise RUN advances per tick
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
        if (S_AXI_ARESET) begin
            state_q    <= ST_IDLE;
            led_q      <= '0;
            step_cnt_q <= '0;
            dir_q      <= DIR_LEFT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (wr_ctrl) begin
            step_cnt_q <= '0;
            dir_q      <= DIR_LEFT;
            done_q     <= 1'b0;
            if (S_AXI_WDATA[0]) begin
                state_q <= ST_RUN;
                led_q   <= seed;
                busy_q  <= 1'b1;
            end else begin
                state_q <= ST_IDLE;
                led_q   <= '0;
                busy_q  <= 1'b0;
            end
        end else if (state_q == ST_RUN && tick) begin
            led_q      <= led_d;
            dir_q      <= dir_d;
            step_cnt_q <= step_inc[STEP_WIDTH-1:0];
            if (last_step) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: scoreboard bench for the LED pattern sequencer
module tb_led_pattern_sequencer;

    localparam logic [2:0] A_CTRL = 3'd0, A_PERIOD = 3'd1, A_PATTERN = 3'd2, A_STEPS = 3'd3;
    localparam logic [2:0] M_STATIC = 3'd0, M_WALK = 3'd1, M_BOUNCE = 3'd2, M_COUNT = 3'd3, M_BLINK = 3'd4;

    typedef struct {
        logic [7:0] led;
        logic       busy;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slv_reg_wren = 1'b0;
    logic [2:0]  axi_awaddr = '0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [7:0]  LED;
    logic        seq_busy;
    logic        seq_done;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    led_pattern_sequencer dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .slv_reg_wren(slv_reg_wren),
        .axi_awaddr  (axi_awaddr),
        .S_AXI_WDATA (S_AXI_WDATA),
        .LED         (LED),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done)
    );

    always #5 clk = ~clk;

    // Reference step: returns {new_dir, new_led}; dir 0 = left, 1 = right
    function automatic logic [8:0] f_step(input logic [2:0] m, input logic [7:0] v, input logic d, input logic [7:0] pat);
        logic [7:0] r;
        logic       nd;
        nd = d;
        case (m)
            M_WALK:   r = {v[6:0], v[7]};
            M_BOUNCE: begin
                r = d ? (v >> 1) : (v << 1);
                if (r[7]) nd = 1'b1;
                else if (r[0]) nd = 1'b0;
            end
            M_COUNT:  r = v + 8'd1;
            M_BLINK:  r = ~v;
            default:  r = pat;
        endcase
        return {nd, r};
    endfunction

    // Writes are presented at a falling edge and taken by the following rising edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        slv_reg_wren = 1'b1;
        axi_awaddr   = a;
        S_AXI_WDATA  = d;
        @(negedge clk);
        slv_reg_wren = 1'b0;
    endtask

    // Expected per-cycle outputs of a sequence started on the preceding edge
    task automatic push_run(input logic [2:0] m, input logic [7:0] seed, input int period, input int steps, input int n);
        logic [7:0] v;
        logic       d;
        logic       dn;
        logic [8:0] r;
        int         cnt;
        int         sc;
        v = seed; d = 1'b0; dn = 1'b0; cnt = 0; sc = 0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{v, !dn, dn});
            if (!dn) begin
                if (cnt >= period) begin
                    r = f_step(m, v, d, seed);
                    d = r[8];
                    v = r[7:0];
                    cnt = 0;
                    sc++;
                    if (steps != 0 && sc >= steps) dn = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back('{8'h00, 1'b0, 1'b0});
    endtask

    // Compare one queued expectation per falling edge, starting at the current one
    task automatic drain(input string name);
        exp_t e;
        int   k;
        k = 0;
        while (exp_q.size() != 0) begin
            if (k != 0) @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({LED, seq_busy, seq_done} !== {e.led, e.busy, e.done}) begin
                errors++;
                $display("FAIL %s cycle %0d: got led=%h busy=%b done=%b, want led=%h busy=%b done=%b",
                         name, k, LED, seq_busy, seq_done, e.led, e.busy, e.done);
            end
            k++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({LED, seq_busy, seq_done} !== 10'b0) begin
            errors++;
            $display("FAIL reset_values: got led=%h busy=%b done=%b, want 00 0 0", LED, seq_busy, seq_done);
        end
        @(negedge clk);
        rst = 1'b0;
        push_idle(3);
        drain("idle_after_reset");
        wr(A_CTRL, 32'h1);
        push_run(M_STATIC, 8'h01, 9_999_999, 0, 4);
        drain("default_pattern");
        wr(A_PERIOD, 32'd3);
        wr(A_CTRL, 32'h3);
        push_run(M_WALK, 8'h01, 3, 0, 7);
        drain("walk_before_reset");
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({LED, seq_busy, seq_done} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset: got led=%h busy=%b done=%b, want 00 0 0", LED, seq_busy, seq_done);
        end
        @(negedge clk);
        rst = 1'b0;
        push_idle(2);
        drain("idle_after_async_reset");
    endtask

    task automatic test_walk();
        wr(A_PERIOD, 32'd3);
        wr(A_PATTERN, 32'h01);
        wr(A_STEPS, 32'd0);
        wr(A_CTRL, 32'h3);
        push_run(M_WALK, 8'h01, 3, 0, 40);
        drain("walk");
    endtask

    task automatic test_bounce();
        wr(A_PERIOD, 32'd0);
        wr(A_PATTERN, 32'h01);
        wr(A_STEPS, 32'd0);
        wr(A_CTRL, 32'h5);
        push_run(M_BOUNCE, 8'h01, 0, 0, 20);
        drain("bounce");
    endtask

    task automatic test_count_steps();
        wr(A_PERIOD, 32'd0);
        wr(A_PATTERN, 32'hFE);
        wr(A_STEPS, 32'd3);
        wr(A_CTRL, 32'h7);
        push_run(M_COUNT, 8'hFE, 0, 3, 8);
        drain("count_steps");
    endtask

    task automatic test_blink_collision();
        wr(A_PERIOD, 32'd3);
        wr(A_PATTERN, 32'h5A);
        wr(A_STEPS, 32'd0);
        wr(A_CTRL, 32'h9);
        push_run(M_BLINK, 8'h5A, 3, 0, 4);
        drain("blink_before_tick");
        wr(A_CTRL, 32'h9);
        push_run(M_BLINK, 8'h5A, 3, 0, 10);
        drain("blink_reseed");
    endtask

    task automatic test_disable_ignore();
        wr(A_CTRL, 32'h0);
        push_idle(3);
        drain("disable");
        wr(A_PERIOD, 32'd1);
        wr(A_PATTERN, 32'h3C);
        wr(3'd4, 32'h7);
        wr(3'd5, 32'h0);
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'h3);
        push_idle(2);
        drain("ignored_addr_idle");
        wr(A_CTRL, 32'h7);
        push_run(M_COUNT, 8'h3C, 1, 0, 10);
        drain("ignored_addr_regs");
    endtask

    initial begin
        test_reset();
        test_walk();
        test_bounce();
        test_count_steps();
        test_blink_collision();
        test_disable_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
